// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the reverse AES-128 key schedule and its consumer.
// The master side issues start/key_in and drives key_ready; the slave side is the key generator.
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         key_valid;
  logic         busy;
  logic         done;
  logic         dbg_state;

  modport master (
    output start, key_in, key_ready,
    input  key_out, round_out, key_valid, busy, done, dbg_state
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_out, round_out, key_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Walks the AES-128 key schedule backward from round key 10 to round key 0,
// emitting one round key per accepted handshake while holding only one 128-bit key.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry a starts at bit (255-a)*8.
  assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_inv_key_sched (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_key_sched_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  v0, v1, v2, v3;
  logic [31:0]  u0, u1, u2, u3;
  logic [31:0]  rot, sub;
  logic [7:0]   rcon;

  assign v0 = key_q[127:96];
  assign v1 = key_q[95:64];
  assign v2 = key_q[63:32];
  assign v3 = key_q[31:0];

  assign u3  = v3 ^ v2;
  assign u2  = v2 ^ v1;
  assign u1  = v1 ^ v0;
  assign rot = {u3[23:0], u3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox sbox (.a(rot[i*8 +: 8]), .y(sub[i*8 +: 8]));
  end

  // round_q is r+1 when stepping to key r, so it selects Rcon directly.
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign u0 = v0 ^ sub ^ {rcon, 24'h000000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Handshake: a key transfers on a rising edge where key_valid and key_ready are both 1;
  // key_out/round_out never change while key_valid is 1 and key_ready is 0.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q blocks a restart in the same cycle the previous sequence reports completion.
        if (bus.start && !done_q) begin
          key_d   = bus.key_in;
          round_d = 4'd10;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.key_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = {u0, u1, u2, u3};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_out   = key_q;
  assign bus.round_out = round_q;
  assign bus.key_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
endmodule
